// File: rtl/io_request_arbiter.sv
// Round-robin arbiter sharing the non-cached I/O bus between cores.
// One transaction in flight: accept, issue strobe, optional read wait, respond.
module io_request_arbiter #(
   parameter int unsigned NUM_REQUESTERS   = 4,
   parameter int unsigned THREAD_IDX_WIDTH = 2
) (
   input  logic                                         clk,
   input  logic                                         reset_n,
   input  logic [NUM_REQUESTERS-1:0]                    req_valid,
   input  logic [NUM_REQUESTERS-1:0]                    req_is_store,
   input  logic [NUM_REQUESTERS*THREAD_IDX_WIDTH-1:0]   req_thread_idx,
   input  logic [NUM_REQUESTERS*32-1:0]                 req_address,
   input  logic [NUM_REQUESTERS*32-1:0]                 req_value,
   output logic [NUM_REQUESTERS-1:0]                    req_ready,
   output logic                                         rsp_valid,
   output logic [3:0]                                   rsp_core,
   output logic [THREAD_IDX_WIDTH-1:0]                  rsp_thread_idx,
   output logic [31:0]                                  rsp_read_value,
   output logic                                         io_write_en,
   output logic                                         io_read_en,
   output logic [31:0]                                  io_address,
   output logic [31:0]                                  io_write_data,
   input  logic [31:0]                                  io_read_data
);

   localparam int unsigned GrantWidth = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

   typedef enum logic [1:0] {StIdle, StIssue, StReadWait, StRespond} state_e;

   state_e                        state_q, state_d;
   logic [GrantWidth-1:0]         last_grant_q, grant_q, grant_idx;
   logic                          grant_found, accept;
   int unsigned                   scan_idx;
   logic                          is_store_q;
   logic [THREAD_IDX_WIDTH-1:0]   thread_q;
   logic [31:0]                   address_q, value_q, read_data_q;

   // Scan upward from the requester after the last grant, wrapping once.
   always_comb begin
      grant_idx   = '0;
      grant_found = 1'b0;
      scan_idx    = 0;
      for (int unsigned k = 0; k < NUM_REQUESTERS; k++) begin
         scan_idx = int'(last_grant_q) + 1 + k;
         if (scan_idx >= NUM_REQUESTERS) scan_idx = scan_idx - NUM_REQUESTERS;
         if (!grant_found && req_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = GrantWidth'(scan_idx);
         end
      end
   end

   assign accept = (state_q == StIdle) && grant_found && reset_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= StIdle;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:     if (accept) state_d = StIssue;
         StIssue:    state_d = is_store_q ? StRespond : StReadWait;
         StReadWait: state_d = StRespond;
         StRespond:  state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_q <= GrantWidth'(NUM_REQUESTERS - 1);
         grant_q      <= '0;
         is_store_q   <= 1'b0;
         thread_q     <= '0;
         address_q    <= '0;
         value_q      <= '0;
         read_data_q  <= '0;
      end else begin
         if (accept) begin
            last_grant_q <= grant_idx;
            grant_q      <= grant_idx;
            is_store_q   <= req_is_store[grant_idx];
            thread_q     <= req_thread_idx[grant_idx*THREAD_IDX_WIDTH +: THREAD_IDX_WIDTH];
            address_q    <= req_address[grant_idx*32 +: 32];
            value_q      <= req_value[grant_idx*32 +: 32];
         end
         if (state_q == StReadWait) read_data_q <= io_read_data;
      end
   end

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[grant_idx] = 1'b1;
      io_write_en    = (state_q == StIssue) && is_store_q;
      io_read_en     = (state_q == StIssue) && !is_store_q;
      // Address and data simply hold the latched request outside ISSUE.
      io_address     = address_q;
      io_write_data  = value_q;
      rsp_valid      = (state_q == StRespond);
      rsp_core       = rsp_valid ? 4'(grant_q) : 4'd0;
      rsp_thread_idx = rsp_valid ? thread_q : '0;
      rsp_read_value = (rsp_valid && !is_store_q) ? read_data_q : 32'd0;
   end

endmodule

// File: tb/tb_io_request_arbiter.sv
// Self-checking bench for io_request_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level round-robin model.
module tb_io_request_arbiter;

   localparam int N  = 4;
   localparam int TW = 2;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_is_store = '0;
   logic [N*TW-1:0] req_thread_idx = '0;
   logic [N*32-1:0] req_address = '0;
   logic [N*32-1:0] req_value = '0;
   logic [N-1:0]    req_ready;
   logic            rsp_valid;
   logic [3:0]      rsp_core;
   logic [TW-1:0]   rsp_thread_idx;
   logic [31:0]     rsp_read_value;
   logic            io_write_en, io_read_en;
   logic [31:0]     io_address, io_write_data;
   logic [31:0]     io_read_data = '0;

   int errors = 0;
   int checks = 0;
   int model_last = N - 1;

   logic [31:0] pay_addr [N];
   logic [31:0] pay_val  [N];
   logic        pay_store[N];
   logic [1:0]  pay_thr  [N];

   // Observation results filled by observe()
   int          o_lat, o_strobe_cyc, o_wr, o_rd;
   logic [31:0] o_addr, o_wdata, o_rval;
   logic [3:0]  o_core;
   logic [1:0]  o_thr;
   bit          o_overlap;

   always #5 clk = ~clk;

   io_request_arbiter #(.NUM_REQUESTERS(N), .THREAD_IDX_WIDTH(TW)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_is_store(req_is_store), .req_thread_idx(req_thread_idx),
      .req_address(req_address), .req_value(req_value), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_core(rsp_core), .rsp_thread_idx(rsp_thread_idx),
      .rsp_read_value(rsp_read_value), .io_write_en(io_write_en), .io_read_en(io_read_en),
      .io_address(io_address), .io_write_data(io_write_data), .io_read_data(io_read_data)
   );

   // Round-robin rule: first valid index strictly after the last grant, modulo N.
   function automatic int model_pick(logic [N-1:0] mask, int last);
      for (int k = 1; k <= N; k++) if (mask[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   task automatic set_req(input int i, input logic st, input logic [1:0] thr,
                          input logic [31:0] a, input logic [31:0] v);
      pay_store[i] = st; pay_thr[i] = thr; pay_addr[i] = a; pay_val[i] = v;
      req_is_store[i] = st;
      req_thread_idx[i*TW +: TW] = thr;
      req_address[i*32 +: 32] = a;
      req_value[i*32 +: 32] = v;
   endtask

   task automatic scramble_live_payloads();
      for (int i = 0; i < N; i++) begin
         req_is_store[i] = 1'($urandom);
         req_thread_idx[i*TW +: TW] = 2'($urandom);
         req_address[i*32 +: 32] = $urandom;
         req_value[i*32 +: 32] = $urandom;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      req_valid = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      model_last = N - 1;
   endtask

   // Present mask and wait (bounded) for a grant; called at a negedge.
   task automatic issue(input logic [N-1:0] mask, input bit drop,
                        output logic [N-1:0] rdy, output int waited);
      req_valid = mask;
      rdy = '0;
      waited = -1;
      for (int w = 0; w < 12; w++) begin
         #1;
         if (|req_ready) begin
            rdy = req_ready;
            waited = w;
            break;
         end
         @(negedge clk);
      end
      if (waited >= 0) begin
         @(posedge clk);
         #1;
         if (drop) req_valid = req_valid & ~rdy;
      end
   endtask

   // Follow one accepted transaction until its response; returns at that negedge.
   task automatic observe(input logic [31:0] bus_data);
      bit pend = 0;
      o_lat = -1; o_strobe_cyc = -1; o_wr = 0; o_rd = 0; o_overlap = 0;
      o_addr = 'x; o_wdata = 'x; o_rval = 'x; o_core = 'x; o_thr = 'x;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (io_write_en && io_read_en) o_overlap = 1;
         if (io_write_en) begin
            o_wr++; o_addr = io_address; o_wdata = io_write_data; o_strobe_cyc = c;
         end
         if (io_read_en) begin
            o_rd++; o_addr = io_address; o_strobe_cyc = c; pend = 1;
         end
         if (rsp_valid) begin
            o_lat = c; o_core = rsp_core; o_thr = rsp_thread_idx; o_rval = rsp_read_value;
            break;
         end
         @(posedge clk);
         #1;
         // Bus data is only meaningful in the cycle after the read strobe.
         if (pend) begin io_read_data = bus_data; pend = 0; end
         else io_read_data = $urandom;
      end
   endtask

   task automatic test_reset();
      req_valid = 4'b1111;
      #3;
      checks++;
      if (req_ready !== 4'b0000) begin errors++;
         $display("FAIL reset_ready got=%b want=0000", req_ready); end
      checks++;
      if ({rsp_valid, io_write_en, io_read_en} !== 3'b000) begin errors++;
         $display("FAIL reset_strobes got=%b want=000", {rsp_valid, io_write_en, io_read_en}); end
      checks++;
      if ({io_address, io_write_data, rsp_read_value, rsp_core, rsp_thread_idx} !== '0) begin
         errors++;
         $display("FAIL reset_data got addr=%h wd=%h rv=%h core=%0d thr=%0d want all 0",
                  io_address, io_write_data, rsp_read_value, rsp_core, rsp_thread_idx);
      end
      req_valid = '0;
      @(negedge clk);
      reset_n = 1'b1;
      model_last = N - 1;
   endtask

   task automatic test_single_store();
      logic [N-1:0] rdy; int w;
      set_req(1, 1'b1, 2'd1, 32'h110, 32'hDEADBEEF);
      issue(4'b0010, 1, rdy, w);
      model_last = 1;
      checks++;
      if (rdy !== 4'b0010 || w != 0) begin errors++;
         $display("FAIL store_ready got=%b wait=%0d want=0010 wait=0", rdy, w); end
      observe(32'h0);
      checks++;
      if (o_strobe_cyc != 1 || o_wr != 1 || o_rd != 0) begin errors++;
         $display("FAIL store_strobe got cyc=%0d wr=%0d rd=%0d want cyc=1 wr=1 rd=0",
                  o_strobe_cyc, o_wr, o_rd); end
      checks++;
      if (o_addr !== 32'h110 || o_wdata !== 32'hDEADBEEF) begin errors++;
         $display("FAIL store_bus got addr=%h wd=%h want 110 deadbeef", o_addr, o_wdata); end
      checks++;
      if (o_lat != 2 || o_core !== 4'd1 || o_thr !== 2'd1 || o_rval !== 32'd0) begin errors++;
         $display("FAIL store_rsp got lat=%0d core=%0d thr=%0d rv=%h want 2 1 1 0",
                  o_lat, o_core, o_thr, o_rval); end
   endtask

   task automatic test_single_load();
      logic [N-1:0] rdy; int w;
      set_req(3, 1'b0, 2'd2, 32'h40, 32'h5555AAAA);
      issue(4'b1000, 1, rdy, w);
      model_last = 3;
      checks++;
      if (rdy !== 4'b1000) begin errors++;
         $display("FAIL load_ready got=%b want=1000", rdy); end
      observe(32'h12345678);
      checks++;
      if (o_strobe_cyc != 1 || o_rd != 1 || o_wr != 0 || o_addr !== 32'h40) begin errors++;
         $display("FAIL load_strobe got cyc=%0d rd=%0d wr=%0d addr=%h want 1 1 0 40",
                  o_strobe_cyc, o_rd, o_wr, o_addr); end
      checks++;
      if (o_lat != 3 || o_core !== 4'd3 || o_thr !== 2'd2 || o_rval !== 32'h12345678) begin
         errors++;
         $display("FAIL load_rsp got lat=%0d core=%0d thr=%0d rv=%h want 3 3 2 12345678",
                  o_lat, o_core, o_thr, o_rval); end
   endtask

   task automatic test_contention();
      logic [N-1:0] rdy; int w; int cnt[N];
      do_reset();
      for (int i = 0; i < N; i++) begin
         cnt[i] = 0;
         set_req(i, 1'($urandom), 2'($urandom), $urandom, $urandom);
      end
      for (int r = 0; r < 5; r++) begin
         issue(4'b1111, 0, rdy, w);
         model_last = r % N;
         checks++;
         if (rdy !== 4'(1 << (r % N))) begin errors++;
            $display("FAIL contention_grant round=%0d got=%b want=%b", r, rdy, 4'(1 << (r % N)));
         end
         observe($urandom);
         if (r < N && o_core < N) cnt[o_core]++;
         checks++;
         if (o_core !== 4'(r % N) || o_lat != (pay_store[r % N] ? 2 : 3)) begin errors++;
            $display("FAIL contention_rsp round=%0d got core=%0d lat=%0d want core=%0d",
                     r, o_core, o_lat, r % N); end
      end
      req_valid = '0;
      for (int i = 0; i < N; i++) begin
         checks++;
         if (cnt[i] != 1) begin errors++;
            $display("FAIL contention_count idx=%0d got=%0d want=1", i, cnt[i]); end
      end
   endtask

   task automatic test_skip();
      logic [N-1:0] rdy; int w;
      logic [N-1:0] want[3];
      logic [N-1:0] masks[3];
      masks[0] = 4'b0010; masks[1] = 4'b0011; masks[2] = 4'b0011;
      want[0]  = 4'b0010; want[1]  = 4'b0001; want[2]  = 4'b0010;
      for (int s = 0; s < 3; s++) begin
         issue(masks[s], 1, rdy, w);
         model_last = model_pick(masks[s], model_last);
         checks++;
         if (rdy !== want[s]) begin errors++;
            $display("FAIL skip_grant step=%0d got=%b want=%b", s, rdy, want[s]); end
         observe($urandom);
      end
      req_valid = '0;
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] rdy; int w;
      set_req(2, 1'b1, 2'd3, 32'hA000_0010, 32'hCAFEF00D);
      issue(4'b0100, 1, rdy, w);
      model_last = 2;
      observe(32'h0);
      checks++;
      if (o_overlap || o_wr != 1 || o_lat != 2 || o_wdata !== 32'hCAFEF00D) begin errors++;
         $display("FAIL b2b_store got ovl=%0d wr=%0d lat=%0d wd=%h", o_overlap, o_wr, o_lat,
                  o_wdata); end
      set_req(2, 1'b0, 2'd0, 32'hA000_0014, 32'h0);
      issue(4'b0100, 1, rdy, w);
      checks++;
      if (rdy !== 4'b0100 || w != 1) begin errors++;
         $display("FAIL b2b_accept got=%b wait=%0d want=0100 wait=1", rdy, w); end
      observe(32'h0BADC0DE);
      checks++;
      if (o_overlap || o_rd != 1 || o_wr != 0 || o_lat != 3 || o_rval !== 32'h0BADC0DE) begin
         errors++;
         $display("FAIL b2b_load got ovl=%0d rd=%0d wr=%0d lat=%0d rv=%h", o_overlap, o_rd,
                  o_wr, o_lat, o_rval); end
   endtask

   task automatic test_reset_mid();
      logic [N-1:0] rdy; int w; int seen;
      // Load from requester 0 so that a surviving pointer would favour requester 3 next.
      set_req(0, 1'b0, 2'd1, 32'h80, 32'h0);
      set_req(3, 1'b1, 2'd0, 32'h84, 32'h77);
      issue(4'b0001, 1, rdy, w);
      @(negedge clk);
      checks++;
      if (io_read_en !== 1'b1) begin errors++;
         $display("FAIL midrst_issue got rd_en=%b want=1", io_read_en); end
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (io_read_en !== 1'b0 || rsp_valid !== 1'b0) begin errors++;
         $display("FAIL midrst_drop got rd_en=%b rsp=%b want 0 0", io_read_en, rsp_valid); end
      @(negedge clk);
      reset_n = 1'b1;
      model_last = N - 1;
      seen = 0;
      repeat (4) begin @(negedge clk); if (rsp_valid) seen++; end
      checks++;
      if (seen != 0) begin errors++;
         $display("FAIL midrst_no_rsp got=%0d responses want=0", seen); end
      issue(4'b1001, 1, rdy, w);
      model_last = 0;
      checks++;
      if (rdy !== 4'b0001) begin errors++;
         $display("FAIL midrst_regrant got=%b want=0001", rdy); end
      observe($urandom);
      // Reset landing in ISSUE of a store must kill the write strobe at once.
      issue(4'b1000, 1, rdy, w);
      checks++;
      if (io_write_en !== 1'b1) begin errors++;
         $display("FAIL issue_rst_pre got wr_en=%b want=1", io_write_en); end
      reset_n = 1'b0;
      #1;
      checks++;
      if (io_write_en !== 1'b0) begin errors++;
         $display("FAIL issue_rst_drop got wr_en=%b want=0", io_write_en); end
      @(negedge clk);
      reset_n = 1'b1;
      model_last = N - 1;
      req_valid = '0;
   endtask

   task automatic test_random();
      logic [N-1:0] rdy, mask; int w, exp;
      logic [31:0] bus, e_addr, e_val; logic e_store; logic [1:0] e_thr;
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < N; i++)
            set_req(i, 1'($urandom), 2'($urandom), $urandom, $urandom);
         mask = 4'($urandom_range(1, 15));
         bus = $urandom;
         exp = model_pick(mask, model_last);
         e_store = pay_store[exp]; e_thr = pay_thr[exp];
         e_addr = pay_addr[exp];   e_val = pay_val[exp];
         issue(mask, 1, rdy, w);
         model_last = exp;
         checks++;
         if (rdy !== 4'(1 << exp)) begin errors++;
            $display("FAIL rand_grant t=%0d mask=%b got=%b want=%b", t, mask, rdy, 4'(1 << exp));
         end
         scramble_live_payloads();
         observe(bus);
         checks++;
         if (o_overlap || o_wr != (e_store ? 1 : 0) || o_rd != (e_store ? 0 : 1) ||
             o_strobe_cyc != 1 || o_addr !== e_addr ||
             (e_store && o_wdata !== e_val)) begin
            errors++;
            $display("FAIL rand_bus t=%0d got wr=%0d rd=%0d cyc=%0d addr=%h wd=%h want st=%0d addr=%h wd=%h",
                     t, o_wr, o_rd, o_strobe_cyc, o_addr, o_wdata, e_store, e_addr, e_val);
         end
         checks++;
         if (o_lat != (e_store ? 2 : 3) || o_core !== 4'(exp) || o_thr !== e_thr ||
             o_rval !== (e_store ? 32'd0 : bus)) begin
            errors++;
            $display("FAIL rand_rsp t=%0d got lat=%0d core=%0d thr=%0d rv=%h want core=%0d thr=%0d",
                     t, o_lat, o_core, o_thr, o_rval, exp, e_thr);
         end
      end
      req_valid = '0;
   endtask

   initial begin
      test_reset();
      test_single_store();
      test_single_load();
      test_contention();
      test_skip();
      test_back_to_back();
      test_reset_mid();
      test_random();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/io_request_arbiter.md
Name: io_request_arbiter

Overview:
- Shares the single non-cached I/O bus (io_bus_interface master side) between NUM_REQUESTERS cores.
- Accepts one ioreq_packet_t-style request at a time, chosen by round-robin, and drives one write_en or read_en strobe on the bus.
- Returns an iorsp_packet_t-style response tagged with core and thread. Only one transaction is outstanding at any time.

Parameters:
- NUM_REQUESTERS, 4, number of requesting cores (legal range 1..16).
- THREAD_IDX_WIDTH, 2, width of thread_idx; equals $clog2(THREADS_PER_CORE).

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQUESTERS  per-core request valid.
- req_is_store  input  NUM_REQUESTERS  1 = write, 0 = read.
- req_thread_idx  input  NUM_REQUESTERS*THREAD_IDX_WIDTH  requesting thread; requester i occupies slice i.
- req_address  input  NUM_REQUESTERS*32  I/O address; requester i occupies slice i.
- req_value  input  NUM_REQUESTERS*32  store data; requester i occupies slice i.
- req_ready  output  NUM_REQUESTERS  request accepted this cycle (one-hot or zero).
- rsp_valid  output  1  response valid, single-cycle pulse.
- rsp_core  output  4  index of the requester being answered (core_id_t).
- rsp_thread_idx  output  THREAD_IDX_WIDTH  thread being answered.
- rsp_read_value  output  32  load data; 0 for stores.
- io_write_en  output  1  bus write strobe.
- io_read_en  output  1  bus read strobe.
- io_address  output  32  bus address.
- io_write_data  output  32  bus write data.
- io_read_data  input  32  bus read data, valid the cycle after io_read_en.

Behaviour:
- Reset (async on reset_n=0):
  - state=IDLE; all registered outputs cleared (rsp_*, io_*); req_ready=0.
  - last_grant=NUM_REQUESTERS-1, so requester 0 has top priority after reset.
- FSM states: IDLE, ISSUE, READ_WAIT, RESPOND.
- IDLE:
  - grant = first asserted req_valid searching upward from last_grant+1, wrapping modulo NUM_REQUESTERS.
  - req_ready[grant]=1 combinationally; req_ready is 0 in every other state.
  - On an accept edge: latch is_store, thread, address, value; record grant index; last_grant<=grant; go to ISSUE.
  - No valid requests: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - io_address and io_write_data driven from latched values.
  - io_write_en=is_store and io_read_en=!is_store, mutually exclusive.
  - Next state: RESPOND for a store, READ_WAIT for a load.
- READ_WAIT (1 cycle): strobes are 0; io_read_data is captured at the end of this cycle; next state RESPOND.
- RESPOND (1 cycle):
  - rsp_valid=1; rsp_core=latched grant zero-extended to 4 bits; rsp_thread_idx=latched thread.
  - rsp_read_value = captured data for a load, 0 for a store.
  - There is no response backpressure. Next state IDLE.
- Latency from accept edge to rsp_valid: store 2 cycles, load 3 cycles.
- Issue rate: a new accept is possible in the first IDLE cycle after RESPOND. Maximum throughput is one store per 3 cycles or one load per 4 cycles.
- Requester rules:
  - Requesters hold req_valid and payload stable until req_ready.
  - Deasserting valid before ready is legal; the request is simply not taken.
  - Payload changes while not granted are ignored.
- io_address and io_write_data hold their last values outside ISSUE; only the strobes are qualified.
- Fairness: a requester with valid asserted is granted within NUM_REQUESTERS accepts.
- Single requester (NUM_REQUESTERS=1): always grants index 0.
- Reset mid-transaction:
  - Strobes and rsp_valid drop immediately (asynchronous); the in-flight transaction is discarded and no response is issued.
  - Round-robin pointer restarts at requester 0.

Test Plan:
- Single store: req_valid=4'b0010, address=0x110, value=0xDEADBEEF, thread=1 -> req_ready=4'b0010 that cycle; next cycle io_write_en=1, io_address=0x110, io_write_data=0xDEADBEEF; following cycle rsp_valid=1, rsp_core=1, rsp_thread_idx=1, rsp_read_value=0.
- Single load: requester 3, address=0x40, bus returns 0x12345678 the cycle after io_read_en -> io_read_en exactly 1 cycle, io_write_en stays 0; rsp_valid 3 cycles after accept, rsp_core=3, rsp_read_value=0x12345678.
- Contention after reset: all four req_valid held high, each request reissued after it is answered -> grant order 0,1,2,3,0; each index responds once per round; req_ready is never multi-hot.
- Skip idle requester: after granting 1, valid=4'b0011 -> next grant 0 (wrap past 2 and 3); then 1.
- Back-to-back: requester 2 issues a store then immediately a load -> second accept occurs in the IDLE cycle following RESPOND; strobes never overlap.
- Reset mid-load: assert reset_n=0 during READ_WAIT -> io_read_en=0 and rsp_valid=0 immediately; no response for that load; after release, a valid=4'b1001 request grants 0 first.
